// File: rtl/mem_align_stage.sv
// Memory-align stage: extracts/zero-extends B/D/W loads and merges misaligned split loads via a hold buffer.
// One-cycle registered latency; whole stage (FSM included) freezes when !clk_en || halt.
module mem_align_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        flush,
  input  logic        bubble_in,
  input  logic [4:0]  opcode_in,
  input  logic [4:0]  tgt_in_1,
  input  logic [4:0]  tgt_in_2,
  input  logic [31:0] result_in_1,
  input  logic [31:0] result_in_2,
  input  logic [31:0] addr_in,
  input  logic        is_load_in,
  input  logic        split_first,
  input  logic        split_second,
  input  logic [7:0]  exc_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [31:0] result_out_1,
  output logic [31:0] result_out_2,
  output logic [4:0]  tgt_out_1,
  output logic [4:0]  tgt_out_2,
  output logic        bubble_out,
  output logic        is_load_out,
  output logic [4:0]  opcode_out,
  output logic [7:0]  exc_out,
  output logic [31:0] pc_out,
  output logic        split_pending
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [1:0]  r_hold_k, w_hold_k_nxt;

  logic [31:0] r_result_1, r_result_2, r_pc;
  logic [4:0]  r_tgt_1, r_tgt_2, r_opcode;
  logic [7:0]  r_exc;
  logic        r_bubble, r_is_load;

  logic        w_adv, w_is_d, w_is_b, w_live_ld, w_first_bub, w_tgt_kill;
  logic [1:0]  w_k;
  logic [5:0]  w_merge_sh;
  logic [31:0] w_shifted, w_merge_src, w_merged, w_ld_raw, w_ld_data, w_res1;
  logic        w_unused_addr;

  assign w_unused_addr = ^addr_in[31:2];

  assign w_adv       = clk_en && !halt;
  assign w_k         = addr_in[1:0];
  assign w_is_d      = (opcode_in >= 5'd6) && (opcode_in <= 5'd8);
  assign w_is_b      = (opcode_in >= 5'd9) && (opcode_in <= 5'd11);
  assign w_live_ld   = is_load_in && !bubble_in;
  assign w_first_bub = split_first && !bubble_in;

  assign w_shifted   = mem_data >> {w_k, 3'b000};
  // Shift of 32 (hold_k = 0) yields zero, so a lone second half contributes nothing from memory.
  assign w_merge_sh  = {3'd4 - {1'b0, r_hold_k}, 3'b000};
  assign w_merge_src = (r_state == S_HOLD) ? r_hold : 32'h0;
  assign w_merged    = w_merge_src | (mem_data << w_merge_sh);
  assign w_ld_raw    = split_second ? w_merged : w_shifted;
  assign w_ld_data   = w_is_b ? (w_ld_raw & 32'h0000_00ff) :
                       w_is_d ? (w_ld_raw & 32'h0000_ffff) : w_ld_raw;
  assign w_res1      = (w_live_ld && !split_first) ? w_ld_data : result_in_1;
  assign w_tgt_kill  = bubble_in || (exc_in != 8'h0) || flush || w_first_bub;

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_hold_k_nxt = r_hold_k;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = 32'h0;
    end else if (w_live_ld && split_first) begin
      w_state_nxt  = S_HOLD;
      w_hold_nxt   = w_shifted;
      w_hold_k_nxt = w_k;
    end else if (w_live_ld && split_second) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_hold   <= 32'h0;
      r_hold_k <= 2'd0;
    end else if (w_adv) begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_hold_k <= w_hold_k_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_1 <= 32'h0;
      r_result_2 <= 32'h0;
      r_tgt_1    <= 5'd0;
      r_tgt_2    <= 5'd0;
      r_bubble   <= 1'b1;
      r_is_load  <= 1'b0;
      r_opcode   <= 5'd0;
      r_exc      <= 8'h0;
      r_pc       <= RESET_PC;
    end else if (w_adv) begin
      r_result_1 <= w_res1;
      r_result_2 <= result_in_2;
      r_tgt_1    <= w_tgt_kill ? 5'd0 : tgt_in_1;
      r_tgt_2    <= w_tgt_kill ? 5'd0 : tgt_in_2;
      r_bubble   <= bubble_in || flush || w_first_bub;
      r_is_load  <= is_load_in && !flush;
      r_opcode   <= opcode_in;
      r_exc      <= (flush || bubble_in) ? 8'h0 : exc_in;
      r_pc       <= pc_in;
    end
  end

  assign result_out_1  = r_result_1;
  assign result_out_2  = r_result_2;
  assign tgt_out_1     = r_tgt_1;
  assign tgt_out_2     = r_tgt_2;
  assign bubble_out    = r_bubble;
  assign is_load_out   = r_is_load;
  assign opcode_out    = r_opcode;
  assign exc_out       = r_exc;
  assign pc_out        = r_pc;
  assign split_pending = (r_state == S_HOLD);

endmodule

// File: tb/tb_mem_align_stage.sv
// Scoreboard bench for mem_align_stage: expectations queued at drive time, popped one cycle later.
module tb_mem_align_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, halt, flush, bubble_in, is_load_in, split_first, split_second;
  logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
  logic [31:0] result_in_1, result_in_2, addr_in, pc_in, mem_data;
  logic [7:0]  exc_in;
  logic [31:0] result_out_1, result_out_2, pc_out;
  logic [4:0]  tgt_out_1, tgt_out_2, opcode_out;
  logic [7:0]  exc_out;
  logic        bubble_out, is_load_out, split_pending;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  t1;
    logic [4:0]  t2;
    logic        bub;
    logic        ld;
    logic [4:0]  op;
    logic [7:0]  exc;
    logic [31:0] pc;
    logic        pend;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } sb_t;

  sb_t  sb[$];
  sb_t  e;
  obs_t obs;
  int   checks = 0;
  int   failures = 0;

  assign obs = {result_out_1, result_out_2, tgt_out_1, tgt_out_2, bubble_out, is_load_out,
                opcode_out, exc_out, pc_out, split_pending};

  mem_align_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .flush(flush),
    .bubble_in(bubble_in), .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
    .result_in_1(result_in_1), .result_in_2(result_in_2), .addr_in(addr_in),
    .is_load_in(is_load_in), .split_first(split_first), .split_second(split_second),
    .exc_in(exc_in), .pc_in(pc_in), .mem_data(mem_data),
    .result_out_1(result_out_1), .result_out_2(result_out_2), .tgt_out_1(tgt_out_1),
    .tgt_out_2(tgt_out_2), .bubble_out(bubble_out), .is_load_out(is_load_out),
    .opcode_out(opcode_out), .exc_out(exc_out), .pc_out(pc_out), .split_pending(split_pending)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] t1,
                              input logic [4:0] t2, input logic bub, input logic ld,
                              input logic [4:0] op, input logic [7:0] exc, input logic [31:0] pc,
                              input logic pend);
    obs_t o;
    o = {r1, r2, t1, t2, bub, ld, op, exc, pc, pend};
    return o;
  endfunction

  // care_r1 = 0 marks result_out_1 as unspecified for that slot (first halves, flushed slots).
  task automatic push(input obs_t v, input logic care_r1);
    sb_t s;
    s.v = v;
    s.m = '1;
    if (!care_r1) s.m.r1 = 32'h0;
    sb.push_back(s);
  endtask

  task automatic nop();
    clk_en = 1'b1; halt = 1'b0; flush = 1'b0; bubble_in = 1'b0; is_load_in = 1'b0;
    split_first = 1'b0; split_second = 1'b0; opcode_in = 5'd0; tgt_in_1 = 5'd0; tgt_in_2 = 5'd0;
    result_in_1 = 32'h0; result_in_2 = 32'h0; addr_in = 32'h0; pc_in = 32'h0; mem_data = 32'h0;
    exc_in = 8'h0;
  endtask

  task automatic load(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] mem,
                      input logic [4:0] t1, input logic [31:0] pc);
    nop();
    is_load_in = 1'b1; opcode_in = op; addr_in = addr; mem_data = mem; tgt_in_1 = t1; pc_in = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nop();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 8'h0, RST_PC, 1'b0), 1'b1);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e.v); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    @(negedge clk);
    load(5'd3, 32'h100, 32'hDEADBEEF, 5'd5, 32'h2000);
    tgt_in_2 = 5'd6; result_in_1 = 32'h1234; result_in_2 = 32'h5555;
    push(mk(32'hDEADBEEF, 32'h5555, 5'd5, 5'd6, 1'b0, 1'b1, 5'd3, 8'h0, 32'h2000, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL word_load got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_byte_double();
    logic [4:0]  ops [5] = '{5'd9, 5'd6, 5'd3, 5'd10, 5'd7};
    logic [31:0] adr [5] = '{32'h102, 32'h102, 32'h102, 32'h103, 32'h101};
    logic [31:0] exp [5] = '{32'h22, 32'h1122, 32'h1122, 32'h11, 32'h2233};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load(ops[i], adr[i], 32'h11223344, 5'd10 + 5'(i), 32'h2100 + 32'(i));
      push(mk(exp[i], 32'h0, 5'd10 + 5'(i), 5'd0, 1'b0, 1'b1, ops[i], 8'h0, 32'h2100 + 32'(i), 1'b0), 1'b1);
      tick();
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL extract_%0d got=%h exp=%h", i, obs, e.v); end
    end
  endtask

  task automatic test_split_word();
    @(negedge clk);
    load(5'd4, 32'h101, 32'hAABBCCDD, 5'd7, 32'h2200); split_first = 1'b1;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 8'h0, 32'h2200, 1'b1), 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL split_w_first got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    load(5'd4, 32'h105, 32'h44332211, 5'd7, 32'h2200); split_second = 1'b1;
    push(mk(32'h11AABBCC, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd4, 8'h0, 32'h2200, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL split_w_second got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_split_double();
    @(negedge clk);
    load(5'd6, 32'h103, 32'h99000000, 5'd3, 32'h2300); split_first = 1'b1;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 8'h0, 32'h2300, 1'b1), 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL split_d_first got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    load(5'd6, 32'h107, 32'h00000077, 5'd3, 32'h2300); split_second = 1'b1;
    push(mk(32'h7799, 32'h0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd6, 8'h0, 32'h2300, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL split_d_second got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_flush_in_hold();
    @(negedge clk);
    load(5'd4, 32'h101, 32'h12345678, 5'd7, 32'h2400); split_first = 1'b1;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 8'h0, 32'h2400, 1'b1), 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL flush_setup got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    load(5'd4, 32'h105, 32'hCAFEF00D, 5'd7, 32'h2404); split_second = 1'b1; flush = 1'b1; exc_in = 8'h05;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd4, 8'h0, 32'h2404, 1'b0), 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL flush_wins got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    load(5'd4, 32'h105, 32'h000000FF, 5'd7, 32'h2408); split_second = 1'b1;
    push(mk(32'hFF000000, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd4, 8'h0, 32'h2408, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL second_after_flush got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_exception();
    @(negedge clk);
    nop(); opcode_in = 5'd20; result_in_1 = 32'hCAFE; tgt_in_1 = 5'd4; tgt_in_2 = 5'd9; exc_in = 8'h03;
    pc_in = 32'h2500;
    push(mk(32'hCAFE, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 8'h03, 32'h2500, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL exception got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    bubble_in = 1'b1; pc_in = 32'h2504;
    push(mk(32'hCAFE, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd20, 8'h00, 32'h2504, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL bubble_exc got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_store_split();
    @(negedge clk);
    nop(); opcode_in = 5'd14; result_in_1 = 32'hAAAA; result_in_2 = 32'h77; tgt_in_1 = 5'd9;
    split_first = 1'b1; pc_in = 32'h2600;
    push(mk(32'hAAAA, 32'h77, 5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 8'h0, 32'h2600, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL store_first got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    split_first = 1'b0; split_second = 1'b1; result_in_1 = 32'hBBBB;
    push(mk(32'hBBBB, 32'h77, 5'd9, 5'd0, 1'b0, 1'b0, 5'd14, 8'h0, 32'h2600, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL store_second got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_stall();
    obs_t a, d;
    a = mk(32'h01020304, 32'h0, 5'd2, 5'd0, 1'b0, 1'b1, 5'd3, 8'h0, 32'h3000, 1'b0);
    d = mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 8'h0, 32'h3008, 1'b1);
    @(negedge clk); load(5'd3, 32'h100, 32'h01020304, 5'd2, 32'h3000); push(a, 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL stall_base got=%h exp=%h", obs, e.v); end
    @(negedge clk); load(5'd9, 32'h101, 32'hFFFFFFFF, 5'd8, 32'h3004); halt = 1'b1; push(a, 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL halt_hold got=%h exp=%h", obs, e.v); end
    @(negedge clk); halt = 1'b0; clk_en = 1'b0; push(a, 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL clken_hold got=%h exp=%h", obs, e.v); end
    @(negedge clk); load(5'd3, 32'h102, 32'h55667788, 5'd8, 32'h3008); split_first = 1'b1; push(d, 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL stall_first got=%h exp=%h", obs, e.v); end
    @(negedge clk); load(5'd3, 32'h106, 32'hDDCCBBAA, 5'd8, 32'h300C); split_second = 1'b1; halt = 1'b1;
    push(d, 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL halt_in_hold got=%h exp=%h", obs, e.v); end
    @(negedge clk); halt = 1'b0;
    push(mk(32'hBBAA5566, 32'h0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd3, 8'h0, 32'h300C, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL merge_after_halt got=%h exp=%h", obs, e.v); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load(5'd4, 32'h101, 32'hAABBCCDD, 5'd7, 32'h3100); split_first = 1'b1;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 8'h0, 32'h3100, 1'b1), 1'b0);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL rst_setup got=%h exp=%h", obs, e.v); end
    #2 rst_n = 1'b0;
    push(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 8'h0, RST_PC, 1'b0), 1'b1);
    #1;
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, e.v); end
    @(negedge clk);
    rst_n = 1'b1;
    load(5'd3, 32'h100, 32'hCAFEBABE, 5'd3, 32'h3104);
    push(mk(32'hCAFEBABE, 32'h0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 8'h0, 32'h3104, 1'b0), 1'b1);
    tick();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL first_after_reset got=%h exp=%h", obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_double();
    test_split_word();
    test_split_double();
    test_flush_in_hold();
    test_exception();
    test_store_split();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
